// File: rtl/i2s_sample_fifo.sv
// Sample FIFO between a producer and an I2S master: primes to PRIME_LEVEL, then pops one
// sample per LCK frame. Optional macro I2S_FIFO_HOLD_EN holds SMP on underrun/fill frames.
module i2s_sample_fifo #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned PRIME_LEVEL = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [15:0]           IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  LCK,
  output logic [15:0]           SMP,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  UNDERRUN,
  output logic                  OVERRUN
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;

  localparam logic [LW-1:0] LEVEL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_PRIME = LW'(PRIME_LEVEL);
  localparam logic [LW-1:0] LEVEL_ONE   = LW'(1);
  localparam logic [PW-1:0] PTR_ONE     = PW'(1);

  typedef enum logic {StFill, StRun} state_e;

  state_e        r_state;
  state_e        w_state_d;
  logic [15:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_d;
  logic [15:0]   r_smp;
  logic [15:0]   w_smp_d;
  logic [15:0]   w_idle_smp;
  logic          r_lck_q;
  logic          r_underrun;
  logic          r_overrun;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_underrun;
  logic          w_frame_start;

  assign w_ready       = (r_level != LEVEL_FULL);
  assign w_push        = IN_VALID & w_ready;
  assign w_frame_start = r_lck_q & ~LCK;

  // Value SMP takes on a frame start that has no sample to play.
`ifdef I2S_FIFO_HOLD_EN
  assign w_idle_smp = r_smp;
`else
  assign w_idle_smp = 16'h0000;
`endif

  always_comb begin
    w_state_d  = r_state;
    w_pop      = 1'b0;
    w_underrun = 1'b0;
    w_smp_d    = r_smp;
    unique case (r_state)
      StFill: begin
        if (r_level >= LEVEL_PRIME) w_state_d = StRun;
        if (w_frame_start) w_smp_d = w_idle_smp;
      end
      StRun: begin
        if (w_frame_start) begin
          if (r_level != '0) begin
            w_pop   = 1'b1;
            w_smp_d = r_mem[r_rd_ptr];
          end else begin
            w_underrun = 1'b1;
            w_state_d  = StFill;
            w_smp_d    = w_idle_smp;
          end
        end
      end
      default: w_state_d = StFill;
    endcase
  end

  always_comb begin
    w_level_d = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_d = r_level + LEVEL_ONE;
      2'b01:   w_level_d = r_level - LEVEL_ONE;
      default: w_level_d = r_level;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= StFill;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_smp      <= '0;
      r_lck_q    <= 1'b0;
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_level    <= w_level_d;
      r_smp      <= w_smp_d;
      r_lck_q    <= LCK;
      r_underrun <= w_underrun;
      r_overrun  <= IN_VALID & ~w_ready;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge CLK) begin
    if (w_push && !RST) r_mem[r_wr_ptr] <= IN_DATA;
  end

  assign IN_READY = w_ready;
  assign SMP      = r_smp;
  assign LEVEL    = r_level;
  assign UNDERRUN = r_underrun;
  assign OVERRUN  = r_overrun;

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Scoreboard bench for i2s_sample_fifo: pushed samples are queued, and each LCK frame start
// pops the queue and compares SMP, LEVEL and UNDERRUN against a small FILL/RUN model.
module tb_i2s_sample_fifo;

  localparam int HALF  = 128;
  localparam int PRIME = 8;
  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic        LCK;
  logic [15:0] SMP;
  logic [4:0]  LEVEL;
  logic        UNDERRUN;
  logic        OVERRUN;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];
  bit          m_run    = 1'b0;
  logic [15:0] last_smp = 16'h0000;

  i2s_sample_fifo #(
    .DEPTH_LOG2 (4),
    .PRIME_LEVEL(PRIME)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .IN_DATA (IN_DATA),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .LCK     (LCK),
    .SMP     (SMP),
    .LEVEL   (LEVEL),
    .UNDERRUN(UNDERRUN),
    .OVERRUN (OVERRUN)
  );

  always #5 CLK = ~CLK;

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    IN_DATA  = d;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    check_eq("push_level", 32'(LEVEL), 32'(exp_q.size()));
  endtask

  // One full LCK frame: high half, falling edge (optionally with a coincident push), low half.
  task automatic do_frame(input bit with_push, input logic [15:0] pdata);
    logic [15:0] exp_smp;
    bit          exp_unf;
    LCK = 1'b1;
    repeat (HALF) tick();
    LCK      = 1'b0;
    IN_VALID = with_push;
    IN_DATA  = pdata;
    tick();
    IN_VALID = 1'b0;
    if (!m_run && exp_q.size() >= PRIME) m_run = 1'b1;
    exp_unf = 1'b0;
    if (m_run && exp_q.size() > 0) begin
      exp_smp = exp_q.pop_front();
    end else begin
      if (m_run) begin
        exp_unf = 1'b1;
        m_run   = 1'b0;
      end
`ifdef I2S_FIFO_HOLD_EN
      exp_smp = last_smp;
`else
      exp_smp = 16'h0000;
`endif
    end
    if (with_push) exp_q.push_back(pdata);
    last_smp = exp_smp;
    check_eq("frame_smp", 32'(SMP), 32'(exp_smp));
    check_eq("frame_underrun", 32'(UNDERRUN), 32'(exp_unf));
    check_eq("frame_level", 32'(LEVEL), 32'(exp_q.size()));
    tick();
    check_eq("underrun_pulse_end", 32'(UNDERRUN), 32'd0);
    repeat (HALF - 2) tick();
    check_eq("smp_held_frame", 32'(SMP), 32'(exp_smp));
  endtask

  initial begin
    RST      = 1'b1;
    LCK      = 1'b0;
    IN_VALID = 1'b0;
    IN_DATA  = 16'h0000;
    repeat (3) tick();
    check_eq("rst_level", 32'(LEVEL), 32'd0);
    check_eq("rst_smp", 32'(SMP), 32'd0);
    check_eq("rst_ready", 32'(IN_READY), 32'd1);
    check_eq("rst_underrun", 32'(UNDERRUN), 32'd0);
    check_eq("rst_overrun", 32'(OVERRUN), 32'd0);
    RST = 1'b0;
    tick();

    // Priming: a frame below PRIME_LEVEL must not pop.
    for (int i = 1; i <= 3; i++) push(16'(i));
    do_frame(1'b0, 16'h0);
    for (int i = 4; i <= 8; i++) push(16'(i));
    check_eq("primed_ready", 32'(IN_READY), 32'd1);
    // Eight frames in order, then the ninth underruns.
    for (int i = 0; i < 8; i++) do_frame(1'b0, 16'h0);
    do_frame(1'b0, 16'h0);

    // Back in FILL: a few pushes and a frame must not pop.
    for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i));
    do_frame(1'b0, 16'h0);
    for (int i = 4; i < 16; i++) push(16'h0100 + 16'(i));
    check_eq("full_ready", 32'(IN_READY), 32'd0);
    check_eq("full_overrun_idle", 32'(OVERRUN), 32'd0);
    IN_DATA  = 16'hDEAD;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    check_eq("overrun_pulse", 32'(OVERRUN), 32'd1);
    check_eq("overrun_level", 32'(LEVEL), 32'd16);
    tick();
    check_eq("overrun_pulse_end", 32'(OVERRUN), 32'd0);
    for (int i = 0; i < 16; i++) do_frame(1'b0, 16'h0);
    do_frame(1'b0, 16'h0);

    // Coincident push and pop at LEVEL=5, with negative samples passing bit-exact.
    for (int i = 0; i < 8; i++) push(16'hF000 | 16'(i * 16'h0111));
    for (int i = 0; i < 3; i++) do_frame(1'b0, 16'h0);
    check_eq("level5", 32'(LEVEL), 32'd5);
    do_frame(1'b1, 16'h7FFF);
    for (int i = 0; i < 5; i++) do_frame(1'b0, 16'h0);

    // Mid-frame reset at LEVEL=10 discards everything.
    for (int i = 0; i < 10; i++) push(16'h2000 + 16'(i));
    LCK = 1'b1;
    repeat (40) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_q.delete();
    m_run    = 1'b0;
    last_smp = 16'h0000;
    check_eq("midrst_level", 32'(LEVEL), 32'd0);
    check_eq("midrst_smp", 32'(SMP), 32'd0);
    check_eq("midrst_ready", 32'(IN_READY), 32'd1);
    do_frame(1'b0, 16'h0);
    for (int i = 0; i < 8; i++) push(16'h3000 + 16'(i));
    do_frame(1'b0, 16'h0);
    do_frame(1'b0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_sample_fifo.md
I2S_SAMPLE_FIFO -- requirements
Module: i2s_sample_fifo

Interface
REQ-001 SHALL have parameter: DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 entries (16).
REQ-002 SHALL have parameter: PRIME_LEVEL, 8, occupancy required before playback starts or restarts.
REQ-003 SHALL have port: CLK  input  1  system clock (12 MHz, the same clock that drives the I2S master).
REQ-004 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: IN_DATA  input  16  producer sample, two's complement.
REQ-006 SHALL have port: IN_VALID  input  1  producer offers IN_DATA.
REQ-007 SHALL have port: IN_READY  output  1  block accepts IN_DATA this cycle.
REQ-008 SHALL have port: LCK  input  1  word clock from the I2S master (left channel = low).
REQ-009 SHALL have port: SMP  output  16  sample to the I2S master, held constant for one whole LCK frame.
REQ-010 SHALL have port: LEVEL  output  DEPTH_LOG2+1  current FIFO occupancy.
REQ-011 SHALL have port: UNDERRUN  output  1  one-cycle pulse when a frame starts with the FIFO empty.
REQ-012 SHALL have port: OVERRUN  output  1  one-cycle pulse when IN_VALID=1 while the FIFO is full.

Function
REQ-013 SHALL implement a circular FIFO using write/read pointers of DEPTH_LOG2 bits that wrap modulo depth; LEVEL SHALL track occupancy from 0 to 2**DEPTH_LOG2.
REQ-014 SHALL drive IN_READY = (LEVEL != depth); a push occurs when IN_VALID & IN_READY, and the data SHALL be written on that CLK edge.
REQ-015 Full and pushing: no write SHALL occur, even when a pop happens in the same cycle; OVERRUN SHALL pulse.
REQ-016 SHALL register LCK once (lck_q); a frame start is the cycle where lck_q=1 and LCK=0 (falling edge).
REQ-017 SHALL have two states: FILL and RUN.
  - FILL: no pops; SMP is driven per REQ-021. Moves to RUN when LEVEL >= PRIME_LEVEL.
  - RUN: on each frame start with LEVEL>0, pop the head entry and load it into SMP at that same edge.
REQ-018 SMP SHALL update at most 1 CLK after the frame-start cycle (2 CLK after the LCK edge) and SHALL NOT change again until the next frame start; both channels of a frame SHALL carry the same sample.
REQ-019 Pop and push in the same cycle SHALL leave LEVEL unchanged and SHALL read the old head.
REQ-020 Frame start in RUN with LEVEL=0: UNDERRUN SHALL pulse for 1 cycle, the state SHALL return to FILL, and SMP SHALL follow REQ-021. A push in the same cycle SHALL NOT bypass to SMP.
REQ-021 Underrun or FILL frame-start SMP value: see Configuration.
REQ-022 No arithmetic SHALL be applied to samples; data SHALL pass bit-exact.

Reset
REQ-023 While RST=1 at a CLK edge: pointers=0, LEVEL=0, state=FILL, SMP=0, lck_q=0, UNDERRUN=0, OVERRUN=0. IN_READY SHALL be 1 after reset.
REQ-024 Reset mid-operation SHALL discard all FIFO contents; no pop SHALL occur in the reset cycle.

Configuration
REQ-025 Macro I2S_FIFO_HOLD_EN.
  - Defined: on underrun and during FILL, SMP SHALL retain its last value.
  - Undefined: SMP SHALL be set to 16'h0000 at each frame start during FILL and at each underrun.

Verification
REQ-026 Reset, then 8 pushes of 16'h0001..16'h0008 with LCK toggling every 128 CLK -> FILL until LEVEL=8; at the next falling edge of LCK, SMP=16'h0001 within 2 CLK, then 16'h0002 on the following frame.
REQ-027 Push 16 samples with no frames -> IN_READY=0 at LEVEL=16; a 17th IN_VALID -> OVERRUN pulses, and LEVEL and contents are unchanged.
REQ-028 Prime to 8 and stop pushing -> 8 frames output in order; the 9th frame start -> UNDERRUN 1-cycle pulse, state FILL, SMP=16'h0008 with I2S_FIFO_HOLD_EN and 16'h0000 without.
REQ-029 Push coincident with a frame-start pop at LEVEL=5 -> LEVEL stays 5, SMP=old head, and the new sample is at the tail.
REQ-030 Assert RST for 1 cycle mid-frame at LEVEL=10 -> LEVEL=0, SMP=0, FILL; no pop or output change at the following LCK edge until re-primed.
